// File: rtl/req_chan_mngr_q_pkg.sv
// Shared definitions for the queued request-channel manager: FSM state
// encodings and the non-atomic atop value.
package req_chan_mngr_q_pkg;

  typedef enum logic [1:0] {
    REQC_MIDLE = 2'b00,
    REQC_MAREQ = 2'b01,
    REQC_MBOUT = 2'b10
  } reqc_state_e;

  localparam logic [5:0] REQC_ATOP_NONE = 6'b000000;

endpackage

// File: rtl/req_chan_mngr_q_fifo.sv
// Request queue: DEPTH-entry synchronous FIFO holding address, sequence number
// and (with REQC_ATOP_EN) the atomic opcode; the head is presented combinationally.
module req_fifo #(
  parameter int ADDR_W = 32,
  parameter int SEQ_W  = 2,
  parameter int DEPTH  = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [SEQ_W-1:0]  in_seq,
`ifdef REQC_ATOP_EN
  input  logic [5:0]        in_atop,
  output logic [5:0]        head_atop,
`endif
  output logic [ADDR_W-1:0] head_addr,
  output logic [SEQ_W-1:0]  head_seq,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty
);

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [SEQ_W-1:0]  seq_mem  [DEPTH];
`ifdef REQC_ATOP_EN
  logic [5:0]        atop_mem [DEPTH];
`endif
  logic [PW-1:0]     wr_ptr_reg;
  logic [PW-1:0]     rd_ptr_reg;
  logic [CW-1:0]     count_reg;

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_reg] <= in_addr;
      seq_mem[wr_ptr_reg]  <= in_seq;
`ifdef REQC_ATOP_EN
      atop_mem[wr_ptr_reg] <= in_atop;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      if (push && !pop)      count_reg <= count_reg + CW'(1);
      else if (pop && !push) count_reg <= count_reg - CW'(1);
    end
  end

  assign count = count_reg;
  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);

  // An empty queue presents zeros rather than stale storage.
  assign head_addr = empty ? '0 : addr_mem[rd_ptr_reg];
  assign head_seq  = empty ? '0 : seq_mem[rd_ptr_reg];
`ifdef REQC_ATOP_EN
  assign head_atop = empty ? '0 : atop_mem[rd_ptr_reg];
`endif

endmodule

// File: rtl/req_chan_mngr_q.sv
// Queued request-channel manager: buffers requests, arbitrates per beat and caps
// in-flight transactions. Optional feature macro: REQC_ATOP_EN (stores atop per entry).
module req_chan_mngr_q
  import req_chan_mngr_q_pkg::*;
#(
  parameter int                M_ID_W    = 2,
  parameter logic [M_ID_W-1:0] REQC_M_ID = '0,
  parameter int                SEQ_W     = 2,
  parameter int                ADDR_W    = 32,
  parameter int                DEPTH     = 4,
  parameter int                MAX_OUTS  = 4,
  localparam int               OW        = $clog2(MAX_OUTS + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic                    req_rq,
  input  logic                    gnt_rq,
  output logic                    a_valid,
  input  logic                    a_ready,
  output logic [M_ID_W+SEQ_W-1:0] a_id,
  output logic [ADDR_W-1:0]       a_addr,
  output logic [5:0]              a_atop,
  input  logic                    start_rq,
  input  logic [ADDR_W-1:0]       in_addr,
  input  logic [5:0]              in_atop,
  output logic                    rq_full,
  output logic                    next_rq,
  output logic [M_ID_W+SEQ_W-1:0] next_id,
  input  logic                    done_rq,
  output logic [OW-1:0]           outs_cnt
);

  localparam int CW  = $clog2(DEPTH + 1);
  localparam int OW1 = OW + 1;

  reqc_state_e       state_reg, state_next;
  logic [SEQ_W-1:0]  seq_reg;
  logic [OW-1:0]     outs_reg;
  logic [OW1-1:0]    outs_next;
  logic              push, pop, done_eff, cap_ok;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full, fifo_empty;
  logic [ADDR_W-1:0] head_addr;
  logic [SEQ_W-1:0]  head_seq;

  assign req_rq  = (state_reg == REQC_MAREQ);
  assign a_valid = (state_reg == REQC_MBOUT);
  assign next_rq = a_valid & a_ready;
  assign pop     = next_rq;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign push    = start_rq & (~fifo_full | pop);

  // A completion with nothing in flight is spurious and ignored.
  assign done_eff  = done_rq & (outs_reg != '0);
  assign outs_next = {1'b0, outs_reg} + OW1'(pop) - OW1'(done_eff);
  assign cap_ok    = (outs_next < OW1'(MAX_OUTS));

  req_fifo #(
    .ADDR_W (ADDR_W),
    .SEQ_W  (SEQ_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .in_addr   (in_addr),
    .in_seq    (seq_reg),
`ifdef REQC_ATOP_EN
    .in_atop   (in_atop),
    .head_atop (a_atop),
`endif
    .head_addr (head_addr),
    .head_seq  (head_seq),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifndef REQC_ATOP_EN
  logic unused_atop;
  assign unused_atop = ^in_atop;
  assign a_atop      = REQC_ATOP_NONE;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      REQC_MIDLE: if (((fifo_count != '0) || push) && cap_ok) state_next = REQC_MAREQ;
      REQC_MAREQ: if (gnt_rq) state_next = REQC_MBOUT;
      REQC_MBOUT: begin
        if (a_ready) begin
          if (((fifo_count > CW'(1)) || push) && cap_ok) state_next = REQC_MAREQ;
          else                                           state_next = REQC_MIDLE;
        end
      end
      default: state_next = REQC_MIDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= REQC_MIDLE;
      seq_reg   <= '0;
      outs_reg  <= '0;
    end else begin
      state_reg <= state_next;
      outs_reg  <= outs_next[OW-1:0];
      if (push) seq_reg <= seq_reg + SEQ_W'(1);
    end
  end

  assign rq_full  = fifo_full;
  assign outs_cnt = outs_reg;
  assign next_id  = {REQC_M_ID, seq_reg};
  // With nothing queued the ID shows what the next push will receive.
  assign a_id     = {REQC_M_ID, (fifo_empty ? seq_reg : head_seq)};
  assign a_addr   = head_addr;

endmodule

// File: tb/tb_req_chan_mngr_q.sv
// Scoreboard bench for req_chan_mngr_q: directed timing scenarios plus random
// traffic checked against a queue-based reference model.
module tb_req_chan_mngr_q;

  localparam int         M_ID_W   = 2;
  localparam logic [1:0] MID      = 2'd2;
  localparam int         SEQ_W    = 2;
  localparam int         ADDR_W   = 32;
  localparam int         DEPTH    = 4;
  localparam int         MAX_OUTS = 2;
  localparam int         OW       = $clog2(MAX_OUTS + 1);

  logic clk = 1'b0;
  logic rst_n;
  logic req_rq, gnt_rq, a_valid, a_ready, start_rq, rq_full, next_rq, done_rq;
  logic [M_ID_W+SEQ_W-1:0] a_id, next_id;
  logic [ADDR_W-1:0] a_addr, in_addr;
  logic [5:0] a_atop, in_atop;
  logic [OW-1:0] outs_cnt;

  always #5 clk = ~clk;

  req_chan_mngr_q #(
    .M_ID_W(M_ID_W), .REQC_M_ID(MID), .SEQ_W(SEQ_W),
    .ADDR_W(ADDR_W), .DEPTH(DEPTH), .MAX_OUTS(MAX_OUTS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_rq(req_rq), .gnt_rq(gnt_rq),
    .a_valid(a_valid), .a_ready(a_ready), .a_id(a_id), .a_addr(a_addr),
    .a_atop(a_atop), .start_rq(start_rq), .in_addr(in_addr), .in_atop(in_atop),
    .rq_full(rq_full), .next_rq(next_rq), .next_id(next_id),
    .done_rq(done_rq), .outs_cnt(outs_cnt)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  seq;
    logic [5:0]  atop;
  } exp_t;

  exp_t sb_q[$];
  int errors = 0;
  int checks = 0;
  int beats  = 0;
  int m_cnt, m_seq, m_outs;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    sb_q.delete();
    m_cnt  = 0;
    m_seq  = 0;
    m_outs = 0;
  endtask

  // Apply one cycle of inputs, update the model, and check registered state after the edge.
  task automatic step(input bit s, input logic [31:0] ad, input logic [5:0] at,
                      input bit g, input bit r, input bit d, output bit fired);
    bit   accepted;
    exp_t e;
    start_rq = s; in_addr = ad; in_atop = at;
    gnt_rq = g; a_ready = r; done_rq = d;
    #1;
    fired    = next_rq;
    accepted = s && ((m_cnt < DEPTH) || fired);
    if (accepted) begin
      e.addr = ad;
      e.seq  = m_seq[1:0];
`ifdef REQC_ATOP_EN
      e.atop = at;
`else
      e.atop = 6'd0;
`endif
      sb_q.push_back(e);
      m_seq = (m_seq + 1) % (1 << SEQ_W);
    end
    m_cnt = m_cnt + (accepted ? 1 : 0) - (fired ? 1 : 0);
    if (d && m_outs > 0) m_outs = m_outs - 1;
    if (fired) m_outs = m_outs + 1;
    @(posedge clk);
    #1;
    chk("outs_cnt", outs_cnt, m_outs);
    chk("rq_full", rq_full, (m_cnt == DEPTH));
    chk("next_id", next_id, {MID, m_seq[1:0]});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start_rq = 0; gnt_rq = 0; a_ready = 0; done_rq = 0; in_addr = 0; in_atop = 0;
    #1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_rq"}, req_rq, 0);
    chk({tag, "_a_valid"}, a_valid, 0);
    chk({tag, "_next_rq"}, next_rq, 0);
    chk({tag, "_rq_full"}, rq_full, 0);
    chk({tag, "_outs_cnt"}, outs_cnt, 0);
    chk({tag, "_a_addr"}, a_addr, 0);
    chk({tag, "_a_atop"}, a_atop, 0);
    chk({tag, "_a_id"}, a_id, {MID, 2'd0});
    chk({tag, "_next_id"}, next_id, {MID, 2'd0});
  endtask

  task automatic drain();
    bit f;
    int n;
    n = 0;
    while (!(m_cnt == 0 && m_outs == 0 && !a_valid && !req_rq) && n < 200) begin
      step(0, 0, 0, 1, 1, 1, f);
      n++;
    end
    chk("drain_done", (n < 200), 1);
  endtask

  // Monitor: every accepted beat is matched against the scoreboard head; stalled beats must hold.
  logic        stall_prev = 1'b0;
  logic [31:0] addr_prev;
  logic [3:0]  id_prev;
  logic [5:0]  atop_prev;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", a_valid, 1);
        chk("stall_addr", a_addr, addr_prev);
        chk("stall_id", a_id, id_prev);
        chk("stall_atop", a_atop, atop_prev);
      end
      if (next_rq) begin
        beats++;
        if (sb_q.size() == 0) begin
          chk("beat_unexpected", 1, 0);
        end else begin
          e = sb_q.pop_front();
          $display("beat %0d: id=%h addr=%h atop=%h (exp id=%h addr=%h)",
                   beats, a_id, a_addr, a_atop, {MID, e.seq}, e.addr);
          chk("beat_addr", a_addr, e.addr);
          chk("beat_id", a_id, {MID, e.seq});
          chk("beat_atop", a_atop, e.atop);
        end
      end
      stall_prev = a_valid && !a_ready;
      addr_prev  = a_addr;
      id_prev    = a_id;
      atop_prev  = a_atop;
    end
  end

  initial begin
    bit f;
    int b0;
    logic [31:0] addr0;
    logic [3:0]  id0;

    rst_n = 1'b0;
    start_rq = 0; gnt_rq = 0; a_ready = 0; done_rq = 0; in_addr = 0; in_atop = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single request: req in t+1, beat in t+2, then completion.
    step(1, 32'h1000, 6'h05, 0, 0, 0, f);
    chk("single_req", req_rq, 1);
    chk("single_valid_early", a_valid, 0);
    chk("single_addr", a_addr, 32'h1000);
    chk("single_id", a_id, {MID, 2'd0});
    step(0, 0, 0, 1, 0, 0, f);
    chk("single_valid", a_valid, 1);
    chk("single_req_drop", req_rq, 0);
    step(0, 0, 0, 0, 1, 0, f);
    chk("single_next_rq", f, 1);
    chk("single_outs", outs_cnt, 1);
    chk("single_idle", req_rq | a_valid, 0);
    step(0, 0, 0, 0, 0, 1, f);

    // Full queue: fifth push dropped, then in-order drain.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1, 32'h2000 + 32'(i) * 32'h10, 6'(i), 0, 0, 0, f);
      if (i == 3) chk("full_after4", rq_full, 1);
    end
    chk("full_drop_next_id", next_id, {MID, 2'd0});
    b0 = beats;
    drain();
    chk("full_beats", beats - b0, 4);

    // Outstanding cap: two beats, then IDLE until a completion.
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 32'h3000 + 32'(i), 0, 0, 0, 0, f);
    b0 = beats;
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 1, 0, f);
    chk("cap_beats2", beats - b0, 2);
    chk("cap_req_low", req_rq, 0);
    chk("cap_valid_low", a_valid, 0);
    chk("cap_outs", outs_cnt, 2);
    step(0, 0, 0, 1, 1, 1, f);
    chk("cap_req_after_done", req_rq, 1);
    step(0, 0, 0, 1, 0, 0, f);
    chk("cap_valid3", a_valid, 1);
    step(0, 0, 0, 0, 1, 0, f);
    chk("cap_fire3", f, 1);
    chk("cap_beats3", beats - b0, 3);
    drain();

    // Simultaneous events: push+pop while full, beat+completion, completion at zero.
    for (int i = 0; i < 4; i++) step(1, 32'h4000 + 32'(i), 0, 0, 0, 0, f);
    step(0, 0, 0, 1, 0, 0, f);
    step(1, 32'h4100, 0, 0, 1, 0, f);
    chk("sim_fire1", f, 1);
    chk("sim_full_kept", rq_full, 1);
    step(0, 0, 0, 1, 0, 0, f);
    step(1, 32'h4200, 0, 0, 1, 1, f);
    chk("sim_fire2", f, 1);
    chk("sim_outs_same", outs_cnt, 1);
    chk("sim_full_kept2", rq_full, 1);
    drain();
    step(0, 0, 0, 0, 0, 1, f);
    chk("sim_done_at_zero", outs_cnt, 0);

    // Stalled beat while pushing; the sequence counter wraps.
    step(1, 32'h5000, 6'h11, 0, 0, 0, f);
    step(0, 0, 0, 1, 0, 0, f);
    addr0 = a_addr;
    id0   = a_id;
    for (int i = 0; i < 5; i++) begin
      step(1, 32'h5100 + 32'(i), 6'(i), 0, 0, 0, f);
      chk("stall_hold_addr", a_addr, addr0);
      chk("stall_hold_id", a_id, id0);
    end
    drain();

    // Reset in BOUT with a transaction in flight.
    step(1, 32'h6000, 0, 0, 0, 0, f);
    step(1, 32'h6004, 0, 1, 0, 0, f);
    step(0, 0, 0, 0, 1, 0, f);
    step(0, 0, 0, 1, 0, 0, f);
    chk("mid_in_bout", a_valid, 1);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_reset_vals("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(0, 0, 0, 1, 1, 0, f);
    chk("midrst_quiet", a_valid | req_rq, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(bit'($urandom_range(0, 1)), $urandom, 6'($urandom_range(0, 63)),
           ($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 3) == 0, f);
    end
    drain();
    chk("sb_empty", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
